// File: rtl/uart_loopback_buffer.sv
// UART capture-and-replay: buffers received frames, replays them on TxD after a debounced press.
// Define UART_PARITY_EN to add an even-parity bit on both the RX and TX paths.
module uart_loopback_buffer #(
  parameter int unsigned BAUD_COUNT    = 108,
  parameter int unsigned BTN_THRESHOLD = 20,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn,
  input  logic                           RxD,
  output logic                           TxD,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           rx_drop,
  output logic                           frame_err,
  output logic                           parity_err
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW  = $clog2(BAUD_COUNT);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned DBW = $clog2(BTN_THRESHOLD + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic                 r_rx_s1, r_rx_s2, r_btn_s1, r_btn_s2;
  logic [DBW-1:0]       r_db_cnt;
  logic                 r_press;
  logic [2:0]           r_rx_state, w_rx_nxt;
  logic [TW-1:0]        r_rx_tmr, w_rx_tmr_nxt;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_commit, r_frame_err, w_rx_tick, w_rx_last, w_rx_par_ok;
  logic [2:0]           r_tx_state, w_tx_nxt;
  logic [TW-1:0]        r_tx_tmr, w_tx_tmr_nxt;
  logic [BW-1:0]        r_tx_bit;
  logic [IW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_word;
  logic                 r_txd, r_busy, w_tx_tick, w_tx_bit_last, w_tx_byte_last;
  logic                 w_tx_start, w_tx_finish, w_commit_ok;
  logic [CW-1:0]        r_count;
  logic                 r_rx_drop;
  logic [DATA_BITS-1:0] r_buf [DEPTH];
`ifdef UART_PARITY_EN
  logic                 r_rx_par_bad, r_parity_err, r_tx_par;
`endif

  // Two-flop synchronisers for the asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_rx_s1  <= RxD;
      r_rx_s2  <= r_rx_s1;
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Debounce: one press pulse per high run that reaches the threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= r_btn_s2 && (r_db_cnt == DBW'(BTN_THRESHOLD - 1));
      if (!r_btn_s2)
        r_db_cnt <= '0;
      else if (r_db_cnt != DBW'(BTN_THRESHOLD))
        r_db_cnt <= r_db_cnt + DBW'(1);
    end
  end

  assign w_rx_tick    = (r_rx_tmr == '0);
  assign w_rx_last    = (r_rx_bit == BW'(DATA_BITS - 1));
  assign w_rx_tmr_nxt = w_rx_tick ? TW'(BAUD_COUNT - 1) : r_rx_tmr - TW'(1);
`ifdef UART_PARITY_EN
  assign w_rx_par_ok  = !r_rx_par_bad;
  assign parity_err   = r_parity_err;
`else
  assign w_rx_par_ok  = 1'b1;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (!r_rx_s2) w_rx_nxt = S_START;
      S_START:  if (w_rx_tick) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_tick && w_rx_last) begin
`ifdef UART_PARITY_EN
        w_rx_nxt = S_PARITY;
`else
        w_rx_nxt = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (w_rx_tick) w_rx_nxt = S_STOP;
`endif
      S_STOP:   if (w_rx_tick) w_rx_nxt = S_IDLE;
      default:  w_rx_nxt = S_IDLE;
    endcase
  end

  // RX datapath: half-bit alignment in IDLE, then mid-bit sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_tmr     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_commit  <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_commit <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_tmr <= TW'(BAUD_COUNT / 2 - 1);
          r_rx_bit <= '0;
`ifdef UART_PARITY_EN
          r_rx_par_bad <= 1'b0;
`endif
        end
        S_START: r_rx_tmr <= w_rx_tmr_nxt;
        S_DATA: begin
          r_rx_tmr <= w_rx_tmr_nxt;
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + BW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          r_rx_tmr <= w_rx_tmr_nxt;
          if (w_rx_tick && ((^r_rx_shift) != r_rx_s2)) begin
            r_rx_par_bad <= 1'b1;
            r_parity_err <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_rx_tmr <= w_rx_tmr_nxt;
          if (w_rx_tick) begin
            if (!r_rx_s2)         r_frame_err <= 1'b1;
            else if (w_rx_par_ok) r_rx_commit <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_commit_ok = r_rx_commit && (r_count < CW'(DEPTH)) && !r_busy;

  // Buffer RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_commit_ok) r_buf[IW'(r_count)] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_rx_drop <= 1'b0;
    end else begin
      if (r_rx_commit && !w_commit_ok) r_rx_drop <= 1'b1;
      if (w_tx_finish)      r_count <= '0;
      else if (w_commit_ok) r_count <= r_count + CW'(1);
    end
  end

  assign w_tx_tick      = (r_tx_tmr == '0);
  assign w_tx_tmr_nxt   = w_tx_tick ? TW'(BAUD_COUNT - 1) : r_tx_tmr - TW'(1);
  assign w_tx_bit_last  = (r_tx_bit == BW'(DATA_BITS - 1));
  assign w_tx_byte_last = ((CW'(r_tx_idx) + CW'(1)) == r_count);
  assign w_tx_word      = r_buf[r_tx_idx];
  // A same-cycle commit counts toward the start condition so that byte is replayed
  assign w_tx_start     = r_press && (r_tx_state == S_IDLE) && !r_busy &&
                          ((r_count != '0) || w_commit_ok);
  assign w_tx_finish    = (r_tx_state == S_STOP) && w_tx_tick && w_tx_byte_last;

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    case (r_tx_state)
      S_IDLE:   if (w_tx_start) w_tx_nxt = S_START;
      S_START:  if (w_tx_tick) w_tx_nxt = S_DATA;
      S_DATA:   if (w_tx_tick && w_tx_bit_last) begin
`ifdef UART_PARITY_EN
        w_tx_nxt = S_PARITY;
`else
        w_tx_nxt = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (w_tx_tick) w_tx_nxt = S_STOP;
`endif
      S_STOP:   if (w_tx_tick) w_tx_nxt = w_tx_byte_last ? S_DONE : S_START;
      S_DONE:   w_tx_nxt = S_IDLE;
      default:  w_tx_nxt = S_IDLE;
    endcase
  end

  // TX datapath: the word is fetched at the end of its start bit, after any pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_idx   <= '0;
      r_tx_tmr   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        S_IDLE: if (w_tx_start) begin
          r_txd    <= 1'b0;
          r_busy   <= 1'b1;
          r_tx_idx <= '0;
          r_tx_tmr <= TW'(BAUD_COUNT - 1);
        end
        S_START: begin
          r_tx_tmr <= w_tx_tmr_nxt;
          if (w_tx_tick) begin
            r_txd      <= w_tx_word[0];
            r_tx_shift <= w_tx_word >> 1;
            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_tx_par   <= ^w_tx_word;
`endif
          end
        end
        S_DATA: begin
          r_tx_tmr <= w_tx_tmr_nxt;
          if (w_tx_tick) begin
            if (w_tx_bit_last) begin
`ifdef UART_PARITY_EN
              r_txd <= r_tx_par;
`else
              r_txd <= 1'b1;
`endif
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + BW'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          r_tx_tmr <= w_tx_tmr_nxt;
          if (w_tx_tick) r_txd <= 1'b1;
        end
`endif
        S_STOP: begin
          r_tx_tmr <= w_tx_tmr_nxt;
          if (w_tx_tick) begin
            if (w_tx_byte_last) begin
              r_busy <= 1'b0;
            end else begin
              r_tx_idx <= r_tx_idx + IW'(1);
              r_txd    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign TxD       = r_txd;
  assign busy      = r_busy;
  assign count     = r_count;
  assign rx_drop   = r_rx_drop;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// Directed bench for uart_loopback_buffer with a byte scoreboard fed by the RX stimulus.
module tb_uart_loopback_buffer;

  localparam int unsigned B     = 108;
  localparam int unsigned THR   = 20;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DB    = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME = (DB + 3) * B;
`else
  localparam int unsigned FRAME = (DB + 2) * B;
`endif

  logic          clk = 1'b0;
  logic          rst, btn, RxD;
  logic          TxD, busy, rx_drop, frame_err, parity_err;
  logic [CW-1:0] count;

  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [7:0]    sb [$];
  logic          mon_en    = 1'b0;
  logic          mon_first = 1'b1;

  uart_loopback_buffer #(
    .BAUD_COUNT(B), .BTN_THRESHOLD(THR), .DEPTH(DEPTH), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .RxD(RxD), .TxD(TxD), .busy(busy),
    .count(count), .rx_drop(rx_drop), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    RxD = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < int'(DB); i++) begin
      RxD = d[i];
      repeat (B) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    RxD = (^d) ^ !par_ok;
    repeat (B) @(negedge clk);
`endif
    if (stop_ok) begin
      RxD = 1'b1;
      repeat (B) @(negedge clk);
    end else begin
      RxD = 1'b0;
      repeat (B / 2 + 8) @(negedge clk);
      RxD = 1'b1;
      repeat (2 * B) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 1'b0;
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_first = 1'b1;
  endtask

  task automatic hold_btn(input int n);
    mon_first = 1'b1;
    btn = 1'b1;
    repeat (n) @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < int'(12 * FRAME)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < int'(12 * FRAME)), 32'd1);
  endtask

  // TX monitor: decodes frames mid-bit and pops the scoreboard
  initial begin : tx_monitor
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    int         last_start;
    p = 1'b0;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (mon_en && TxD === 1'b0) begin
        if (!mon_first) check("frame_period", cyc - last_start, FRAME);
        mon_first  = 1'b0;
        last_start = cyc;
        repeat (B / 2) @(negedge clk);
        check("tx_start_bit", 32'(TxD), 32'd0);
        d = '0;
        for (int i = 0; i < int'(DB); i++) begin
          repeat (B) @(negedge clk);
          d[i] = TxD;
        end
`ifdef UART_PARITY_EN
        repeat (B) @(negedge clk);
        p = TxD;
`endif
        repeat (B) @(negedge clk);
        check("tx_stop_bit", 32'(TxD), 32'd1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL tx_unexpected_frame: observed %0h expected no frame", d);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(d), 32'(e));
`ifdef UART_PARITY_EN
          check("tx_parity", 32'(p), 32'(^e));
`endif
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] t1 [8];
    logic       seen_low;
    int         n;
    t1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    rst = 1'b1;
    btn = 1'b0;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", 32'({rx_drop, frame_err, parity_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: eight bytes captured, then replayed back-to-back
    mon_en = 1'b1;
    foreach (t1[i]) begin
      send_byte(t1[i], 1'b1, 1'b1);
      sb.push_back(t1[i]);
    end
    check("t1_count", 32'(count), 32'd8);
    check("t1_rx_drop", 32'(rx_drop), 32'd0);
    mon_first = 1'b1;
    btn = 1'b1;
    n = 0;
    while (TxD !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("press_latency", n, THR + 3);
    check("t1_busy_up", 32'(busy), 32'd1);
    repeat (150 - n) @(negedge clk);
    btn = 1'b0;
    wait_idle("t1_replay_done");
    repeat (2) @(negedge clk);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_count_end", 32'(count), 32'd0);

    // 2: short press is ignored, a full press replays
    do_reset();
    send_byte(8'h55, 1'b1, 1'b1);
    btn = 1'b1;
    repeat (15) @(negedge clk);
    btn = 1'b0;
    seen_low = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (TxD !== 1'b1) seen_low = 1'b1;
    end
    check("t2_txd_idle", 32'(seen_low), 32'd0);
    check("t2_count", 32'(count), 32'd1);
    sb.push_back(8'h55);
    hold_btn(40);
    wait_idle("t2_replay_done");

    // 3: overflow drops the ninth byte
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(i), 1'b1, 1'b1);
      if (i < int'(DEPTH)) sb.push_back(8'(i));
    end
    check("t3_count", 32'(count), 32'd8);
    check("t3_rx_drop", 32'(rx_drop), 32'd1);
    hold_btn(30);
    wait_idle("t3_replay_done");
    check("t3_count_end", 32'(count), 32'd0);

    // 4: framing error discards, next good byte is kept
    do_reset();
    send_byte(8'h5A, 1'b0, 1'b1);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_count_bad", 32'(count), 32'd0);
    send_byte(8'hA5, 1'b1, 1'b1);
    check("t4_count_good", 32'(count), 32'd1);
    sb.push_back(8'hA5);
    hold_btn(30);
    wait_idle("t4_replay_done");

    // 5: false start, then reset in the middle of a replay
    do_reset();
    send_byte(8'h00, 1'b1, 1'b1);
    RxD = 1'b0;
    repeat (30) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("t5_count", 32'(count), 32'd1);
    check("t5_flags", 32'({rx_drop, frame_err, parity_err}), 32'd0);
    mon_en = 1'b0;
    btn = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy_seen", 32'(n < 100), 32'd1);
    repeat (300) @(negedge clk);
    check("t5_mid_txd", 32'(TxD), 32'd0);
    rst = 1'b1;
    btn = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_txd", 32'(TxD), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

`ifdef UART_PARITY_EN
    // 6: parity mismatch drops the byte, good parity is replayed
    do_reset();
    mon_en = 1'b1;
    send_byte(8'h07, 1'b1, 1'b0);
    check("t6_parity_err", 32'(parity_err), 32'd1);
    check("t6_count_bad", 32'(count), 32'd0);
    send_byte(8'h03, 1'b1, 1'b1);
    check("t6_count_good", 32'(count), 32'd1);
    sb.push_back(8'h03);
    hold_btn(30);
    wait_idle("t6_replay_done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
